// File: rtl/reset_sequencer.sv
// Reset manager: synchronises PLL lock and push button, debounces the button, and releases
// N_OUT reset domains in order. Any fault re-enters reset, records the cause and counts the event.
module reset_sequencer #(
  parameter int unsigned N_OUT           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 64,
  parameter int unsigned STAGE_GAP       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_lock,
  input  logic             btn_n,
  input  logic             sw_reset_req,
  output logic [N_OUT-1:0] rst_out,
  output logic             ready,
  output logic [1:0]       cause,
  output logic [7:0]       reset_count
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  localparam logic [N_OUT-1:0] ALL_ONES  = {N_OUT{1'b1}};
  localparam logic [N_OUT-1:0] FIRST_REL = ALL_ONES << 1;

  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_BTN  = 2'b10;
  localparam logic [1:0] CAUSE_SW   = 2'b11;

  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

  logic lock_m, lock_s, btn_m, btn_s, btn_db;
  logic [DB_W-1:0] db_cnt;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [N_OUT-1:0]  rst_out_d, rst_shift;
  logic              ready_d;
  logic [1:0]        cause_d;
  logic [7:0]        count_d;
  logic              press, qualified, fault;

  // Two-flop synchronisers; button idles released
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      btn_m  <= 1'b1;
      btn_s  <= 1'b1;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
      btn_m  <= btn_n;
      btn_s  <= btn_m;
    end
  end

  // Debounced state flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign press     = ~btn_db;
  assign qualified = lock_s & ~press;
  assign fault     = ~lock_s | press | sw_reset_req;
  assign rst_shift = rst_out << 1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HOLD;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      rst_out     <= ALL_ONES;
      ready       <= 1'b0;
      cause       <= 2'b00;
      reset_count <= 8'd0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rst_out     <= rst_out_d;
      ready       <= ready_d;
      cause       <= cause_d;
      reset_count <= count_d;
    end
  end

  // Next state; rst_out only ever shifts in zeros from bit 0 or snaps back to all ones
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rst_out_d  = rst_out;
    ready_d    = 1'b0;
    cause_d    = cause;
    count_d    = reset_count;

    case (state_q)
      HOLD: begin
        gap_cnt_d = '0;
        rst_out_d = ALL_ONES;
        if (!qualified) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          hold_cnt_d = '0;
          rst_out_d  = FIRST_REL;
          state_d    = (FIRST_REL == '0) ? RUN : RELEASE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      RELEASE: begin
        if (!fault) begin
          if (gap_cnt_q == GAP_W'(STAGE_GAP - 1)) begin
            gap_cnt_d = '0;
            rst_out_d = rst_shift;
            if (rst_shift == '0) state_d = RUN;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end
      RUN: begin
        ready_d = ~fault;
      end
      default: begin
        state_d = HOLD;
      end
    endcase

    if ((state_q == RELEASE || state_q == RUN) && fault) begin
      state_d    = HOLD;
      hold_cnt_d = '0;
      gap_cnt_d  = '0;
      rst_out_d  = ALL_ONES;
      ready_d    = 1'b0;
      if (!lock_s)     cause_d = CAUSE_LOCK;
      else if (press)  cause_d = CAUSE_BTN;
      else             cause_d = CAUSE_SW;
      if (reset_count != 8'hFF) count_d = reset_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with small parameters so release timing is easy to count.
module tb_reset_sequencer;

  localparam int unsigned N_OUT = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             pll_lock;
  logic             btn_n;
  logic             sw_reset_req;
  logic [N_OUT-1:0] rst_out;
  logic             ready;
  logic [1:0]       cause;
  logic [7:0]       reset_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .N_OUT(N_OUT),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(8),
    .STAGE_GAP(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pll_lock(pll_lock),
    .btn_n(btn_n),
    .sw_reset_req(sw_reset_req),
    .rst_out(rst_out),
    .ready(ready),
    .cause(cause),
    .reset_count(reset_count)
  );

  // Advance n rising edges, sampling 1 time unit after the last
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] rst, input logic [31:0] rdy,
                           input logic [31:0] cse, input logic [31:0] cnt);
    check({tag, ".rst_out"}, 32'(rst_out), rst);
    check({tag, ".ready"}, 32'(ready), rdy);
    check({tag, ".cause"}, 32'(cause), cse);
    check({tag, ".count"}, 32'(reset_count), cnt);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 60) begin
      tick(1);
      n++;
    end
    check(tag, 32'(ready), 32'd1);
  endtask

  initial begin
    reset_n      = 1'b0;
    pll_lock     = 1'b1;
    btn_n        = 1'b1;
    sw_reset_req = 1'b0;
    #23;
    check_all("por_in_reset", 32'h7, 0, 0, 0);

    // POR release: edges 10, 12, 14; ready at 15
    @(negedge clk);
    reset_n = 1'b1;
    tick(9);
    check_all("por_e9", 32'h7, 0, 0, 0);
    tick(1);
    check("por_e10", 32'(rst_out), 32'h6);
    tick(2);
    check("por_e12", 32'(rst_out), 32'h4);
    tick(2);
    check_all("por_e14", 32'h0, 0, 0, 0);
    tick(1);
    check_all("por_e15", 32'h0, 1, 0, 0);

    // Lock loss: all-reset on the third edge
    pll_lock = 1'b0;
    tick(2);
    check_all("lock_e2", 32'h0, 1, 0, 0);
    tick(1);
    check_all("lock_e3", 32'h7, 0, 1, 1);
    pll_lock = 1'b1;
    tick(9);
    check("relock_e9", 32'(rst_out), 32'h7);
    tick(1);
    check("relock_e10", 32'(rst_out), 32'h6);
    tick(2);
    check("relock_e12", 32'(rst_out), 32'h4);
    tick(2);
    check_all("relock_e14", 32'h0, 0, 1, 1);
    tick(1);
    check("relock_e15", 32'(ready), 32'd1);

    // Bouncing button never settles long enough
    for (int k = 0; k < 5; k++) begin
      btn_n = 1'b0;
      tick(2);
      btn_n = 1'b1;
      tick(2);
    end
    check_all("bounce", 32'h0, 1, 1, 1);
    btn_n = 1'b0;
    tick(6);
    check("press_e6", 32'(rst_out), 32'h0);
    tick(1);
    check_all("press_e7", 32'h7, 0, 2, 2);
    btn_n = 1'b1;
    tick(13);
    check("unpress_e13", 32'(rst_out), 32'h7);
    tick(1);
    check("unpress_e14", 32'(rst_out), 32'h6);
    tick(4);
    check("unpress_e18", 32'(rst_out), 32'h0);
    tick(1);
    check_all("unpress_e19", 32'h0, 1, 2, 2);

    // Software request from RUN
    sw_reset_req = 1'b1;
    tick(1);
    sw_reset_req = 1'b0;
    check_all("sw_run", 32'h7, 0, 3, 3);

    // Lock loss and software request on the same edge during RELEASE
    tick(7);
    check("sim_e7", 32'(rst_out), 32'h7);
    tick(1);
    check("sim_e8", 32'(rst_out), 32'h6);
    pll_lock = 1'b0;
    tick(2);
    check("sim_e10", 32'(rst_out), 32'h4);
    sw_reset_req = 1'b1;
    tick(1);
    sw_reset_req = 1'b0;
    check_all("sim_fault", 32'h7, 0, 1, 4);

    // Software request in HOLD is ignored
    sw_reset_req = 1'b1;
    tick(1);
    sw_reset_req = 1'b0;
    check_all("sw_hold_nolock", 32'h7, 0, 1, 4);
    pll_lock = 1'b1;
    tick(4);
    sw_reset_req = 1'b1;
    tick(1);
    sw_reset_req = 1'b0;
    check_all("sw_hold_lock", 32'h7, 0, 1, 4);
    wait_ready("ready_after_hold_sw");
    check_all("run_after_hold_sw", 32'h0, 1, 1, 4);

    // Asynchronous reset mid-run
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async_reset", 32'h7, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready("ready_after_async");
    check_all("run_after_async", 32'h0, 1, 0, 0);

    // Saturation of reset_count
    for (int i = 0; i < 260; i++) begin
      sw_reset_req = 1'b1;
      tick(1);
      sw_reset_req = 1'b0;
      if (i == 0) check_all("sat_first", 32'h7, 0, 3, 1);
      if (i == 254) check("sat_255", 32'(reset_count), 32'd255);
      wait_ready("sat_ready");
    end
    check_all("sat_final", 32'h0, 1, 3, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
